// File: rtl/axis_slave_fifo.sv
// AXI-Stream slave receiver: FWFT FIFO with sideband, plus packet/byte statistics.
// Optional store-and-forward mode is enabled by defining AXIS_PKT_MODE_EN.
module axis_slave_fifo #(
  parameter int unsigned n     = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     tvalid,
  output logic                     tready,
  input  logic [8*n-1:0]           tdata,
  input  logic [n-1:0]             tstrb,
  input  logic [n-1:0]             tkeep,
  input  logic                     tlast,
  input  logic                     TID,
  input  logic                     TDEST,
  input  logic                     TUSER,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [8*n-1:0]           rd_data,
  output logic [n-1:0]             rd_strb,
  output logic [n-1:0]             rd_keep,
  output logic                     rd_last,
  output logic [2:0]               rd_side,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         last_pkt_bytes
`ifdef AXIS_PKT_MODE_EN
  ,
  output logic                     err_oversize
`endif
);

  localparam int unsigned DW = 8 * n;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DW + 2 * n + 4;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head_c;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt_c;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] keep_bytes_c;
  logic [CNT_W:0]   acc_sum_c;
  logic [CNT_W-1:0] acc_sat_c;
  logic             accept_c;
  logic             store_c;
  logic             pop_c;
  logic             full_c;
  logic             empty_c;

  function automatic logic [CNT_W-1:0] popcnt(input logic [n-1:0] k);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < n; i++) s = s + CNT_W'(k[i]);
    return s;
  endfunction

  // Null beats are consumed but only kept when they carry the packet boundary.
  assign accept_c    = tvalid && tready;
  assign store_c     = accept_c && ((|tkeep) || tlast);
  assign pop_c       = rd_en && rd_valid;
  assign full_c      = (fifo_count == CW'(DEPTH));
  assign empty_c     = (fifo_count == '0);
  assign count_nxt_c = fifo_count + CW'(store_c) - CW'(pop_c);

  assign head_c   = mem[rd_ptr];
  assign rd_data  = head_c[EW-1 -: DW];
  assign rd_strb  = head_c[4+n +: n];
  assign rd_keep  = head_c[4 +: n];
  assign rd_last  = head_c[3];
  assign rd_side  = head_c[2:0];

  always_ff @(posedge aclk) begin
    if (store_c) mem[wr_ptr] <= {tdata, tstrb, tkeep, tlast, TID, TDEST, TUSER};
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tready     <= 1'b0;
    end else begin
      if (store_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt_c;
      tready     <= (count_nxt_c != CW'(DEPTH));
    end
  end

  assign keep_bytes_c = popcnt(tkeep);
  assign acc_sum_c    = {1'b0, acc} + {1'b0, keep_bytes_c};
  assign acc_sat_c    = acc_sum_c[CNT_W] ? '1 : acc_sum_c[CNT_W-1:0];

  // Byte accumulator saturates; packet counter wraps.
  always_ff @(posedge aclk) begin
    if (areset) begin
      acc            <= '0;
      pkt_count      <= '0;
      last_pkt_bytes <= '0;
    end else if (accept_c) begin
      if (tlast) begin
        last_pkt_bytes <= acc_sat_c;
        acc            <= '0;
        pkt_count      <= pkt_count + CNT_W'(1);
      end else begin
        acc <= acc_sat_c;
      end
    end
  end

`ifdef AXIS_PKT_MODE_EN
  typedef enum logic [1:0] {HOLD, SEND, FLUSH} state_t;

  state_t        state;
  state_t        state_nxt_c;
  logic [CW-1:0] pkts;
  logic [CW-1:0] pkts_nxt_c;
  logic          err_nxt_c;

  assign pkts_nxt_c = pkts + CW'(store_c && tlast) - CW'(pop_c && rd_last);
  assign rd_valid   = (state != HOLD) && !empty_c;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= HOLD;
      pkts         <= '0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_nxt_c;
      pkts         <= pkts_nxt_c;
      err_oversize <= err_nxt_c;
    end
  end

  // Release only complete packets; a packet that fills the FIFO is flushed through.
  always_comb begin
    state_nxt_c = state;
    err_nxt_c   = 1'b0;
    case (state)
      HOLD: begin
        if (pkts != '0) begin
          state_nxt_c = SEND;
        end else if (full_c) begin
          state_nxt_c = FLUSH;
          err_nxt_c   = 1'b1;
        end
      end
      SEND:    if (pop_c && rd_last && (pkts_nxt_c == '0)) state_nxt_c = HOLD;
      FLUSH:   if (pop_c && rd_last) state_nxt_c = HOLD;
      default: state_nxt_c = HOLD;
    endcase
  end
`else
  assign rd_valid = !empty_c;
`endif

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Randomized and directed bench for axis_slave_fifo against a queue-based reference model.
module tb_axis_slave_fifo;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          MAXB  = (1 << CNT_W) - 1;

  logic             aclk = 1'b0;
  logic             areset;
  logic             tvalid;
  logic             tready;
  logic [8*N-1:0]   tdata;
  logic [N-1:0]     tstrb;
  logic [N-1:0]     tkeep;
  logic             tlast;
  logic             tid, tdest, tuser;
  logic             rd_en;
  logic             rd_valid;
  logic [8*N-1:0]   rd_data;
  logic [N-1:0]     rd_strb;
  logic [N-1:0]     rd_keep;
  logic             rd_last;
  logic [2:0]       rd_side;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] last_pkt_bytes;
`ifdef AXIS_PKT_MODE_EN
  logic             err_oversize;
`endif

  axis_slave_fifo #(.n(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
    .TID(tid), .TDEST(tdest), .TUSER(tuser), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_strb(rd_strb), .rd_keep(rd_keep),
    .rd_last(rd_last), .rd_side(rd_side), .fifo_count(fifo_count),
    .pkt_count(pkt_count), .last_pkt_bytes(last_pkt_bytes)
`ifdef AXIS_PKT_MODE_EN
    , .err_oversize(err_oversize)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [8*N-1:0] d;
    logic [N-1:0]   s;
    logic [N-1:0]   k;
    logic           l;
    logic [2:0]     side;
  } ent_t;

  ent_t q[$];
  bit   m_ready;
  int   m_acc, m_pkts, m_bytes;
  bit   accepted;
  bit   toggle;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a queue of stored beats plus byte/packet bookkeeping.
  task automatic model_update();
    bit pop;
    if (areset) begin
      q.delete();
      m_ready = 0; m_acc = 0; m_pkts = 0; m_bytes = 0;
    end else begin
      pop = rd_en && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (tvalid && m_ready) begin
        if (tkeep != 0 || tlast) q.push_back('{tdata, tstrb, tkeep, tlast, {tid, tdest, tuser}});
        m_acc = m_acc + $countones(tkeep);
        if (m_acc > MAXB) m_acc = MAXB;
        if (tlast) begin
          m_bytes = m_acc;
          m_acc   = 0;
          m_pkts  = (m_pkts + 1) % (MAXB + 1);
        end
      end
      m_ready = (q.size() != DEPTH);
    end
  endtask

  task automatic compare();
    check_eq("tready", 64'(tready), 64'(m_ready));
    check_eq("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    check_eq("fifo_count", 64'(fifo_count), 64'(q.size()));
    check_eq("pkt_count", 64'(pkt_count), 64'(m_pkts));
    check_eq("last_pkt_bytes", 64'(last_pkt_bytes), 64'(m_bytes));
    if (q.size() != 0) begin
      check_eq("rd_data", 64'(rd_data), 64'(q[0].d));
      check_eq("rd_strb", 64'(rd_strb), 64'(q[0].s));
      check_eq("rd_keep", 64'(rd_keep), 64'(q[0].k));
      check_eq("rd_last", 64'(rd_last), 64'(q[0].l));
      check_eq("rd_side", 64'(rd_side), 64'(q[0].side));
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic tick();
    accepted = tvalid && tready && !areset;
    @(posedge aclk);
`ifndef AXIS_PKT_MODE_EN
    model_update();
`endif
    @(negedge aclk);
`ifndef AXIS_PKT_MODE_EN
    compare();
`endif
    if (toggle) rd_en = ~rd_en;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [N-1:0] k, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tstrb  = ~k;
    tkeep  = k;
    tlast  = l;
    {tid, tdest, tuser} = 3'(d);
    accepted = 0;
    for (int t = 0; t < 64 && !accepted; t++) tick();
    if (!accepted) check_eq("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int cycles);
    tvalid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    areset = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '0; tkeep = '0; tlast = 1'b0;
    tid = 1'b0; tdest = 1'b0; tuser = 1'b0; rd_en = 1'b0; toggle = 0;
    @(negedge aclk);
    for (int i = 0; i < 3; i++) tick();
    areset = 1'b0;

`ifdef AXIS_PKT_MODE_EN
    begin
      int exp_d;
      int pulses;
      tick();
      rd_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        send_beat(32'(i), 4'hF, i == 4);
        if (i < 4) check_eq("hold_valid", 64'(rd_valid), 64'(0));
      end
      tvalid = 1'b0;
      for (int t = 0; t < 8 && !rd_valid; t++) tick();
      check_eq("pkt_release", 64'(rd_valid), 64'(1));
      exp_d = 1;
      for (int t = 0; t < 8 && exp_d <= 4; t++) begin
        if (rd_valid) begin
          check_eq("pkt_data", 64'(rd_data), 64'(exp_d));
          exp_d++;
        end
        tick();
      end
      check_eq("pkt_drained", 64'(exp_d), 64'(5));
      check_eq("pkt_idle", 64'(rd_valid), 64'(0));

      rd_en = 1'b0;
      for (int i = 17; i <= 32; i++) send_beat(32'(i), 4'hF, 1'b0);
      tvalid = 1'b1; tdata = 32'd33; tkeep = 4'hF; tlast = 1'b0;
      pulses = 0;
      for (int t = 0; t < 4; t++) begin
        tick();
        pulses += int'(err_oversize);
      end
      check_eq("err_pulse", 64'(pulses), 64'(1));
      check_eq("flush_valid", 64'(rd_valid), 64'(1));
      tlast = 1'b1;
      rd_en = 1'b1;
      exp_d = 17;
      for (int t = 0; t < 60; t++) begin
        if (rd_valid) begin
          check_eq("flush_data", 64'(rd_data), 64'(exp_d));
          exp_d++;
        end
        tick();
        if (accepted) tvalid = 1'b0;
      end
      check_eq("flush_drained", 64'(exp_d), 64'(34));
      check_eq("flush_idle", 64'(rd_valid), 64'(0));
    end
`else
    // Short packet with continuous read.
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) send_beat(32'(i), 4'hF, i == 3);
    idle(3);
    check_eq("t1_pkts", 64'(pkt_count), 64'(1));
    check_eq("t1_bytes", 64'(last_pkt_bytes), 64'(12));

    // Fill to full, then drain while the remaining beats trickle in.
    rd_en = 1'b0;
    for (int i = 1; i <= 16; i++) send_beat(32'(i), 4'hF, 1'b0);
    tvalid = 1'b1; tdata = 32'd17;
    tick(); tick();
    check_eq("t2_count", 64'(fifo_count), 64'(16));
    check_eq("t2_ready", 64'(tready), 64'(0));
    rd_en = 1'b1;
    for (int i = 17; i <= 20; i++) send_beat(32'(i), 4'hF, i == 20);
    idle(20);
    check_eq("t2_empty", 64'(fifo_count), 64'(0));

    // Throttled reader across pointer wrap.
    toggle = 1; rd_en = 1'b0;
    for (int i = 0; i < 40; i++) send_beat(32'(100 + i), 4'hF, i == 39);
    toggle = 0; rd_en = 1'b1;
    idle(40);

    // Null beats: only the keyed beat and the null tlast survive.
    rd_en = 1'b0;
    send_beat(32'h55, 4'h0, 1'b0);
    send_beat(32'h66, 4'h3, 1'b0);
    send_beat(32'h77, 4'h0, 1'b1);
    idle(1);
    check_eq("t4_count", 64'(fifo_count), 64'(2));
    check_eq("t4_bytes", 64'(last_pkt_bytes), 64'(2));
    rd_en = 1'b1;
    idle(4);

    // Accumulator saturation.
    for (int i = 0; i < 70; i++) send_beat(32'(i), 4'hF, i == 69);
    idle(20);
    check_eq("sat_bytes", 64'(last_pkt_bytes), 64'(MAXB));

    // Reset mid-packet.
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'(200 + i), 4'hF, 1'b0);
    tvalid = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_eq("rst_count", 64'(fifo_count), 64'(0));
    check_eq("rst_valid", 64'(rd_valid), 64'(0));
    check_eq("rst_pkts", 64'(pkt_count), 64'(0));
    rd_en = 1'b1;
    send_beat(32'h1, 4'h1, 1'b0);
    send_beat(32'h2, 4'h8, 1'b1);
    idle(3);
    check_eq("rst_bytes", 64'(last_pkt_bytes), 64'(2));

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      tvalid = ($urandom_range(3) != 0);
      tdata  = $urandom;
      tstrb  = 4'($urandom);
      tkeep  = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom);
      tlast  = ($urandom_range(5) == 0);
      {tid, tdest, tuser} = 3'($urandom);
      rd_en  = ($urandom_range(2) != 0);
      areset = ($urandom_range(299) == 0);
      tick();
    end
    areset = 1'b0;
    idle(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
